receiver: RTL and testbench

Serial-to-parallel receive block: the inbound half of the UART link whose outbound half is `transmitter`. It recovers 8N1 frames from the `rx` line:
- start bit 0;
- eight data bits, LSB first;
- stop bit 1.

Each recovered byte is presented on a held output with a read handshake, and the block flags framing errors and overruns. The default bit time of one clock matches the transmitter's one-bit-per-clock output, so the two connect directly for loopback.

---
 rtl/receiver.sv | 90 +++++++++
 tb/tb_receiver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/receiver.sv
// receiver: 8N1 UART receive block with a held output byte, read handshake, framing-error pulse and sticky overrun.
module receiver #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state, state_n;
  logic s1, rx_s;
  logic [TW-1:0] tick, tick_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] sh, sh_n;
  logic good, bad, load, bit_end, half_end;
  assign bit_end = tick == TW'(CLKS_PER_BIT - 1);
  assign half_end = tick == TW'(HALF - 1);
  assign load = good && (!dout_valid || rd_en);
  // tick restarts at 0 after every sample so the next sample lands one bit time later
  always_comb begin
    state_n = state;
    tick_n = tick + 1'b1;
    bit_n = bit_cnt;
    sh_n = sh;
    good = 1'b0;
    bad = 1'b0;
    case (state)
      IDLE: begin
        tick_n = '0;
        if (!rx_s) state_n = HALF == 0 ? DATA : START;
      end
      START: if (half_end) begin
        tick_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        tick_n = '0;
        sh_n[bit_cnt] = rx_s;
        bit_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = STOP;
      end
      STOP: if (bit_end) begin
        tick_n = '0;
        good = rx_s;
        bad = !rx_s;
        state_n = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        tick_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      tick <= '0;
      bit_cnt <= '0;
      sh <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      rx_busy <= 1'b0;
    end else begin
      s1 <= rx;
      rx_s <= s1;
      state <= state_n;
      tick <= tick_n;
      bit_cnt <= bit_n;
      sh <= sh_n;
      dout <= load ? sh : dout;
      dout_valid <= load || (dout_valid && !rd_en);
      frame_err <= bad;
      overrun <= !rd_en && (overrun || (good && dout_valid));
      rx_busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: scoreboard bench for receiver at 1 and 16 clocks per bit.
module tb_receiver;
  typedef struct {logic [7:0] d; int t;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic rx1 = 1'b1, rx16 = 1'b1, rd1 = 1'b0, rd16 = 1'b0;
  logic [7:0] dout1, dout16;
  logic v1, v16, fe1, fe16, ov1, ov16, busy1, busy16;
  exp_t q1[$], q16[$];
  int ncmp = 0, nerr = 0, cyc = 0, fec1 = 0, fec16 = 0;
  logic pv1 = 1'b0, pv16 = 1'b0;
  logic [7:0] pd1 = '0, pd16 = '0;

  receiver #(.CLKS_PER_BIT(1)) u1 (.clk(clk), .rst(rst), .rx(rx1), .rd_en(rd1), .dout(dout1),
    .dout_valid(v1), .frame_err(fe1), .overrun(ov1), .rx_busy(busy1));
  receiver #(.CLKS_PER_BIT(16)) u16 (.clk(clk), .rst(rst), .rx(rx16), .rd_en(rd16), .dout(dout16),
    .dout_valid(v16), .frame_err(fe16), .overrun(ov16), .rx_busy(busy16));

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  // monitor: a delivery is dout_valid rising or dout changing while valid
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (v1 && (!pv1 || dout1 != pd1)) begin
      if (q1.size() == 0) chk("unexpected_byte1", dout1, -1);
      else begin
        e = q1.pop_front();
        chk("dout1", dout1, e.d);
        chk("latency1", cyc, e.t);
      end
    end
    if (v16 && (!pv16 || dout16 != pd16)) begin
      if (q16.size() == 0) chk("unexpected_byte16", dout16, -1);
      else begin
        e = q16.pop_front();
        chk("dout16", dout16, e.d);
        chk("latency16", cyc, e.t);
      end
    end
    fec1 += fe1 ? 1 : 0;
    fec16 += fe16 ? 1 : 0;
    pv1 = v1; pd1 = dout1; pv16 = v16; pd16 = dout16;
  end

  task automatic send(input bit sel, input logic [7:0] b, input logic stop, input bit deliver);
    logic [9:0] f;
    int cpb;
    exp_t e;
    f = {stop, b, 1'b0};
    cpb = sel ? 16 : 1;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < cpb; j++) begin
        @(negedge clk);
        if (sel) rx16 = f[i]; else rx1 = f[i];
        if (i == 0 && j == 0 && deliver) begin
          e.d = b;
          e.t = cyc + 3 + cpb / 2 + 9 * cpb;
          if (sel) q16.push_back(e); else q1.push_back(e);
        end
      end
  endtask

  task automatic read_when_valid(input bit sel);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? v16 : v1) && n < 400);
    chk(sel ? "read_wait16" : "read_wait1", int'(sel ? v16 : v1), 1);
    if (sel) rd16 = 1'b1; else rd1 = 1'b1;
    @(negedge clk);
    rd1 = 1'b0;
    rd16 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    chk("rst_dout1", dout1, 0); chk("rst_valid1", v1, 0); chk("rst_busy1", busy1, 0);
    chk("rst_ov1", ov1, 0); chk("rst_fe1", fe1, 0); chk("rst_valid16", v16, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // loopback A5 then 3C back-to-back
    fork
      begin send(0, 8'hA5, 1, 1); send(0, 8'h3C, 1, 1); end
      begin read_when_valid(0); read_when_valid(0); end
    join
    repeat (4) @(negedge clk);
    chk("loop_ov", ov1, 0); chk("loop_fe", fec1, 0); chk("loop_valid", v1, 0);
    // framing error then 20-clock break
    send(0, 8'hFF, 0, 0);
    repeat (20) @(negedge clk);
    chk("break_busy", busy1, 1); chk("break_fe", fec1, 1); chk("break_valid", v1, 0);
    rx1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("break_busy_hold", busy1, 1);
    @(posedge clk);
    #1 chk("break_busy_fall", busy1, 0);
    repeat (2) @(negedge clk);
    fork send(0, 8'h55, 1, 1); read_when_valid(0); join
    // overrun
    send(0, 8'h11, 1, 1);
    send(0, 8'h22, 1, 0);
    repeat (3) @(negedge clk);
    chk("ovr_dout", dout1, 8'h11); chk("ovr_flag", ov1, 1); chk("ovr_valid", v1, 1);
    rd1 = 1'b1;
    @(negedge clk);
    rd1 = 1'b0;
    chk("ovr_clr_valid", v1, 0); chk("ovr_clr_flag", ov1, 0);
    fork send(0, 8'h33, 1, 1); read_when_valid(0); join
    // read exactly at the delivery edge of 77
    send(0, 8'h66, 1, 1);
    send(0, 8'h77, 1, 1);
    @(negedge clk);
    @(negedge clk);
    rd1 = 1'b1;
    @(negedge clk);
    rd1 = 1'b0;
    chk("simul_dout", dout1, 8'h77); chk("simul_valid", v1, 1); chk("simul_ov", ov1, 0);
    rd1 = 1'b1;
    @(negedge clk);
    rd1 = 1'b0;
    // 16x: 4-clock glitch is a false start
    rx16 = 1'b0;
    repeat (4) @(negedge clk);
    rx16 = 1'b1;
    chk("glitch_busy", busy16, 1);
    repeat (30) @(negedge clk);
    chk("glitch_idle", busy16, 0); chk("glitch_valid", v16, 0); chk("glitch_fe", fec16, 0);
    fork send(1, 8'hC3, 1, 1); read_when_valid(1); join
    // reset during data bit 4
    @(negedge clk); rx1 = 1'b0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); rx1 = i[0]; end
    chk("mid_busy", busy1, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dout", dout1, 0); chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_valid", v1, 0); chk("mid_rst_ov", ov1, 0);
    rx1 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    fork send(0, 8'h81, 1, 1); read_when_valid(0); join
    repeat (5) @(negedge clk);
    chk("q1_left", q1.size(), 0); chk("q16_left", q16.size(), 0);
    chk("fe1_total", fec1, 1); chk("fe16_total", fec16, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
